// File: rtl/blackjack_table_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : blackjack_table_ctrl_if
// Brief    : Card source request/valid handshake between table ctrl and deck.
// Revision : 1.0 - initial release
// ============================================================================
interface blackjack_table_ctrl_if #(
    parameter int VAL_W = 4,
    parameter int SYM_W = 2
) ();
    logic             card_req;
    logic             card_vld;
    logic [VAL_W-1:0] card_value;
    logic [SYM_W-1:0] card_symbol;

    modport master (output card_req, input card_vld, input card_value, input card_symbol);
    modport slave  (input card_req, output card_vld, output card_value, output card_symbol);
endinterface
`default_nettype wire

// File: rtl/blackjack_table_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : blackjack_table_ctrl
// Brief    : One-player blackjack controller: draws cards, scores hands, runs
//            dealer auto-play and decides the winner.
//            Optional macro BLACKJACK_DEALER_H17_EN: dealer hits on soft 17.
// Revision : 1.0 - initial release
// ============================================================================
module blackjack_table_ctrl #(
    parameter int MAX_CARDS    = 9,
    parameter int VAL_W        = 4,
    parameter int SYM_W        = 2,
    parameter int DEALER_STAND = 17
) (
    input  wire logic                         clk,
    input  wire logic                         rst,
    input  wire logic                         deal,
    input  wire logic                         hit,
    input  wire logic                         stand,
    input  wire logic                         new_game,
    blackjack_table_ctrl_if.master            card,
    output logic [MAX_CARDS*VAL_W-1:0]        player_values,
    output logic [MAX_CARDS*SYM_W-1:0]        player_symbols,
    output logic [MAX_CARDS*VAL_W-1:0]        dealer_values,
    output logic [MAX_CARDS*SYM_W-1:0]        dealer_symbols,
    output logic [3:0]                        player_count,
    output logic [3:0]                        dealer_count,
    output logic [6:0]                        player_score,
    output logic [6:0]                        dealer_score,
    output logic                              dealer_hide,
    output logic [2:0]                        state_btn,
    output logic [1:0]                        result
);

    localparam logic [2:0] C_DEAL_CARDS = 3'd4;
    localparam logic [3:0] C_MAX_CNT    = 4'(MAX_CARDS);
    localparam logic [6:0] C_STAND      = 7'(DEALER_STAND);
    localparam logic [6:0] C_BJ         = 7'd21;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_DEAL        = 3'd1,
        S_PLAYER_TURN = 3'd2,
        S_PLAYER_DRAW = 3'd3,
        S_DEALER_TURN = 3'd4,
        S_DEALER_DRAW = 3'd5,
        S_RESULT      = 3'd6
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [2:0]       r_draw_cnt;
    logic             r_req;
    logic [1:0]       r_result;
    logic [1:0]       w_result_next;
    logic [1:0]       w_outcome;
    logic [3:0]       r_p_cnt;
    logic [3:0]       r_d_cnt;
    logic [VAL_W-1:0] r_p_val [MAX_CARDS];
    logic [SYM_W-1:0] r_p_sym [MAX_CARDS];
    logic [VAL_W-1:0] r_d_val [MAX_CARDS];
    logic [SYM_W-1:0] r_d_sym [MAX_CARDS];
    logic             w_need_draw;
    logic             w_req_next;
    logic             w_take;
    logic             w_to_player;
    logic             w_clear;
    logic [6:0]       w_p_sum;
    logic [6:0]       w_d_sum;
    logic             w_p_ace;
    logic             w_d_ace;
    logic             w_d_soft;
    logic             w_dealer_hits;

    function automatic logic [6:0] card_points(input logic [VAL_W-1:0] v);
        if (v >= VAL_W'(10)) return 7'd10;
        return 7'(v);
    endfunction

    // Empty slots hold 0, so they add no points and never count as an ace.
    always_comb begin
        w_p_sum = '0;
        w_d_sum = '0;
        w_p_ace = 1'b0;
        w_d_ace = 1'b0;
        for (int i = 0; i < MAX_CARDS; i++) begin
            w_p_sum = w_p_sum + card_points(r_p_val[i]);
            w_d_sum = w_d_sum + card_points(r_d_val[i]);
            if (r_p_val[i] == VAL_W'(1)) w_p_ace = 1'b1;
            if (r_d_val[i] == VAL_W'(1)) w_d_ace = 1'b1;
        end
    end

    assign w_d_soft     = w_d_ace && (w_d_sum <= 7'd11);
    assign player_score = (w_p_ace && (w_p_sum <= 7'd11)) ? w_p_sum + 7'd10 : w_p_sum;
    assign dealer_score = w_d_soft ? w_d_sum + 7'd10 : w_d_sum;

`ifdef BLACKJACK_DEALER_H17_EN
    assign w_dealer_hits = (dealer_score < C_STAND) || (w_d_soft && (dealer_score == 7'd17));
`else
    assign w_dealer_hits = (dealer_score < C_STAND);
`endif

    always_comb begin
        w_outcome = 2'd3;
        if (player_score > C_BJ)              w_outcome = 2'd2;
        else if (dealer_score > C_BJ)         w_outcome = 2'd1;
        else if (player_score > dealer_score) w_outcome = 2'd1;
        else if (player_score < dealer_score) w_outcome = 2'd2;
    end

    assign w_take        = r_req & card.card_vld;
    assign w_req_next    = w_need_draw & ~w_take;
    assign card.card_req = r_req;

    always_comb begin
        w_state_next  = r_state;
        w_result_next = r_result;
        w_clear       = 1'b0;
        w_need_draw   = 1'b0;
        w_to_player   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (deal) w_state_next = S_DEAL;
            end
            S_DEAL: begin
                w_need_draw = (r_draw_cnt < C_DEAL_CARDS);
                w_to_player = ~r_draw_cnt[0];
                if (!w_need_draw)
                    w_state_next = (player_score == C_BJ) ? S_RESULT : S_PLAYER_TURN;
            end
            S_PLAYER_TURN: begin
                if (stand || (hit && (r_p_cnt >= C_MAX_CNT))) w_state_next = S_DEALER_TURN;
                else if (hit)                                  w_state_next = S_PLAYER_DRAW;
            end
            S_PLAYER_DRAW: begin
                w_need_draw = (r_draw_cnt == 3'd0);
                w_to_player = 1'b1;
                if (!w_need_draw) begin
                    if (player_score > C_BJ)
                        w_state_next = S_RESULT;
                    else if ((player_score == C_BJ) || (r_p_cnt >= C_MAX_CNT))
                        w_state_next = S_DEALER_TURN;
                    else
                        w_state_next = S_PLAYER_TURN;
                end
            end
            S_DEALER_TURN: begin
                if (w_dealer_hits && (r_d_cnt < C_MAX_CNT)) w_state_next = S_DEALER_DRAW;
                else                                         w_state_next = S_RESULT;
            end
            S_DEALER_DRAW: begin
                w_need_draw = (r_draw_cnt == 3'd0);
                if (!w_need_draw) w_state_next = S_DEALER_TURN;
            end
            S_RESULT: begin
                if (new_game) begin
                    w_state_next  = S_IDLE;
                    w_clear       = 1'b1;
                    w_result_next = 2'd0;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        if ((w_state_next == S_RESULT) && (r_state != S_RESULT))
            w_result_next = w_outcome;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_draw_cnt <= '0;
            r_req      <= 1'b0;
            r_result   <= 2'd0;
            r_p_cnt    <= '0;
            r_d_cnt    <= '0;
            for (int i = 0; i < MAX_CARDS; i++) begin
                r_p_val[i] <= '0;
                r_p_sym[i] <= '0;
                r_d_val[i] <= '0;
                r_d_sym[i] <= '0;
            end
        end else begin
            r_state  <= w_state_next;
            r_req    <= w_req_next;
            r_result <= w_result_next;
            // Draw progress is per-state, so any transition restarts it.
            if (w_state_next != r_state) r_draw_cnt <= '0;
            else if (w_take)             r_draw_cnt <= r_draw_cnt + 3'd1;
            if (w_clear) begin
                r_p_cnt <= '0;
                r_d_cnt <= '0;
                for (int i = 0; i < MAX_CARDS; i++) begin
                    r_p_val[i] <= '0;
                    r_p_sym[i] <= '0;
                    r_d_val[i] <= '0;
                    r_d_sym[i] <= '0;
                end
            end else if (w_take) begin
                if (w_to_player && (r_p_cnt < C_MAX_CNT)) begin
                    for (int i = 0; i < MAX_CARDS; i++) begin
                        if (r_p_cnt == 4'(i)) begin
                            r_p_val[i] <= card.card_value;
                            r_p_sym[i] <= card.card_symbol;
                        end
                    end
                    r_p_cnt <= r_p_cnt + 4'd1;
                end else if (!w_to_player && (r_d_cnt < C_MAX_CNT)) begin
                    for (int i = 0; i < MAX_CARDS; i++) begin
                        if (r_d_cnt == 4'(i)) begin
                            r_d_val[i] <= card.card_value;
                            r_d_sym[i] <= card.card_symbol;
                        end
                    end
                    r_d_cnt <= r_d_cnt + 4'd1;
                end
            end
        end
    end

    for (genvar i = 0; i < MAX_CARDS; i++) begin : g_pack
        assign player_values [i*VAL_W +: VAL_W] = r_p_val[i];
        assign player_symbols[i*SYM_W +: SYM_W] = r_p_sym[i];
        assign dealer_values [i*VAL_W +: VAL_W] = r_d_val[i];
        assign dealer_symbols[i*SYM_W +: SYM_W] = r_d_sym[i];
    end

    always_comb begin
        state_btn = 3'd2;
        case (r_state)
            S_IDLE:        state_btn = 3'd0;
            S_PLAYER_TURN: state_btn = 3'd1;
            S_RESULT:      state_btn = 3'd3;
            default:       state_btn = 3'd2;
        endcase
    end

    assign dealer_hide  = (r_state == S_DEAL) || (r_state == S_PLAYER_TURN) ||
                          (r_state == S_PLAYER_DRAW);
    assign player_count = r_p_cnt;
    assign dealer_count = r_d_cnt;
    assign result       = r_result;

endmodule
`default_nettype wire

// File: tb/tb_blackjack_table_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_blackjack_table_ctrl
// Brief    : Directed scoreboard bench for blackjack_table_ctrl (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_blackjack_table_ctrl;

    localparam int MAX_CARDS = 9;
    localparam int VAL_W     = 4;
    localparam int SYM_W     = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic deal = 1'b0, hit = 1'b0, stand = 1'b0, new_game = 1'b0;

    logic [MAX_CARDS*VAL_W-1:0] player_values, dealer_values;
    logic [MAX_CARDS*SYM_W-1:0] player_symbols, dealer_symbols;
    logic [3:0] player_count, dealer_count;
    logic [6:0] player_score, dealer_score;
    logic       dealer_hide;
    logic [2:0] state_btn;
    logic [1:0] result;

    blackjack_table_ctrl_if #(.VAL_W(VAL_W), .SYM_W(SYM_W)) card_bus ();

    blackjack_table_ctrl #(.MAX_CARDS(MAX_CARDS), .VAL_W(VAL_W), .SYM_W(SYM_W),
                           .DEALER_STAND(17)) dut (
        .clk(clk), .rst(rst), .deal(deal), .hit(hit), .stand(stand), .new_game(new_game),
        .card(card_bus),
        .player_values(player_values), .player_symbols(player_symbols),
        .dealer_values(dealer_values), .dealer_symbols(dealer_symbols),
        .player_count(player_count), .dealer_count(dealer_count),
        .player_score(player_score), .dealer_score(dealer_score),
        .dealer_hide(dealer_hide), .state_btn(state_btn), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] pc;
        logic [3:0] dc;
        logic [6:0] ps;
        logic [6:0] ds;
        logic [2:0] st;
        logic [1:0] res;
        logic       hide;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int pc, input int dc, input int ps, input int ds,
                        input int st, input int res, input int hide);
        exp_t e;
        e.pc = 4'(pc); e.dc = 4'(dc); e.ps = 7'(ps); e.ds = 7'(ds);
        e.st = 3'(st); e.res = 2'(res); e.hide = 1'(hide);
        exp_q.push_back(e);
    endtask

    task automatic check(input string tag);
        exp_t e;
        vectors++;
        assert (exp_q.size() > 0) else begin
            miscompares++;
            $error("FAIL %s observed=no_entry expected=entry", tag);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp({tag, "_pcount"}, 32'(player_count), 32'(e.pc));
            cmp({tag, "_dcount"}, 32'(dealer_count), 32'(e.dc));
            cmp({tag, "_pscore"}, 32'(player_score), 32'(e.ps));
            cmp({tag, "_dscore"}, 32'(dealer_score), 32'(e.ds));
            cmp({tag, "_state"},  32'(state_btn),    32'(e.st));
            cmp({tag, "_result"}, 32'(result),       32'(e.res));
            cmp({tag, "_hide"},   32'(dealer_hide),  32'(e.hide));
        end
    endtask

    task automatic pulse(input logic d, input logic h, input logic s, input logic n);
        deal = d; hit = h; stand = s; new_game = n;
        @(negedge clk);
        deal = 1'b0; hit = 1'b0; stand = 1'b0; new_game = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (card_bus.card_req !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        cmp({tag, "_req"}, 32'(card_bus.card_req), 32'd1);
    endtask

    // Plays the card source: answer the pending request after 'delay' cycles.
    task automatic serve(input int val, input int sym, input int delay, input string tag);
        wait_req(tag);
        for (int k = 0; k < delay; k++) begin
            @(negedge clk);
            cmp({tag, "_hold"}, 32'(card_bus.card_req), 32'd1);
        end
        card_bus.card_vld    = 1'b1;
        card_bus.card_value  = VAL_W'(val);
        card_bus.card_symbol = SYM_W'(sym);
        @(negedge clk);
        card_bus.card_vld    = 1'b0;
        card_bus.card_value  = '0;
        card_bus.card_symbol = '0;
        cmp({tag, "_drop"}, 32'(card_bus.card_req), 32'd0);
    endtask

    task automatic wait_state(input int target, input string tag);
        int n = 0;
        while (state_btn !== 3'(target) && n < 40) begin
            @(negedge clk);
            n++;
        end
        cmp(tag, 32'(state_btn), 32'(target));
    endtask

    int hit_vals [7] = '{2, 2, 2, 2, 2, 1, 1};
    int hit_dly  [7] = '{0, 0, 5, 0, 0, 0, 0};

    initial begin
        card_bus.card_vld    = 1'b0;
        card_bus.card_value  = '0;
        card_bus.card_symbol = '0;

        repeat (3) @(negedge clk);
        push(0, 0, 0, 0, 0, 0, 0);
        check("reset");
        cmp("reset_req", 32'(card_bus.card_req), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Unsolicited card while idle must be ignored
        card_bus.card_vld = 1'b1; card_bus.card_value = 4'd7;
        @(negedge clk);
        card_bus.card_vld = 1'b0; card_bus.card_value = '0;
        cmp("stray_vld_pcount", 32'(player_count), 32'd0);

        // Deal P5 D1 P9 D7
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        serve(5, 3, 0, "deal0");
        serve(1, 0, 0, "deal1");
        serve(9, 1, 0, "deal2");
        serve(7, 2, 0, "deal3");
        wait_state(1, "deal_turn");
        push(2, 2, 14, 18, 1, 0, 1);
        check("deal");
        cmp("p_slot0", 32'(player_values[3:0]), 32'd5);
        cmp("p_slot1", 32'(player_values[7:4]), 32'd9);
        cmp("p_slot2", 32'(player_values[11:8]), 32'd0);
        cmp("p_sym0",  32'(player_symbols[1:0]), 32'd3);
        cmp("p_sym1",  32'(player_symbols[3:2]), 32'd1);
        cmp("d_slot0", 32'(dealer_values[3:0]), 32'd1);
        cmp("d_slot1", 32'(dealer_values[7:4]), 32'd7);
        cmp("d_sym1",  32'(dealer_symbols[3:2]), 32'd2);

        // Hit a queen: 24, player bust
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        serve(12, 0, 0, "bust_card");
        wait_state(3, "bust_state");
        push(3, 2, 24, 18, 3, 2, 0);
        check("bust");
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            cmp("bust_noreq", 32'(card_bus.card_req), 32'd0);
        end

        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        push(0, 0, 0, 0, 0, 0, 0);
        check("newgame");
        cmp("newgame_pvals", 32'(|player_values), 32'd0);
        pulse(1'b0, 1'b1, 1'b1, 1'b0);
        cmp("idle_ignores", 32'(state_btn), 32'd0);

        // Reset in the middle of a pending card request
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        serve(2, 0, 0, "mid0");
        serve(3, 1, 0, "mid1");
        wait_req("mid2");
        #2 rst = 1'b0;
        #1;
        push(0, 0, 0, 0, 0, 0, 0);
        check("midrst");
        cmp("midrst_req", 32'(card_bus.card_req), 32'd0);
        cmp("midrst_dvals", 32'(|dealer_values), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Player 10,8 vs dealer 6,A (soft 17); hit and stand together
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        serve(10, 0, 0, "s17_0");
        serve(6, 1, 0, "s17_1");
        serve(8, 2, 0, "s17_2");
        serve(1, 3, 0, "s17_3");
        wait_state(1, "s17_turn");
        push(2, 2, 18, 17, 1, 0, 1);
        check("s17_deal");
        pulse(1'b0, 1'b1, 1'b1, 1'b0);
        cmp("s17_dealer_busy", 32'(state_btn), 32'd2);
`ifdef BLACKJACK_DEALER_H17_EN
        serve(3, 0, 0, "s17_draw");
        wait_state(3, "s17_res_state");
        push(2, 3, 18, 20, 3, 2, 0);
`else
        wait_state(3, "s17_res_state");
        push(2, 2, 18, 17, 3, 1, 0);
`endif
        check("s17_result");
        pulse(1'b0, 1'b0, 1'b0, 1'b1);

        // Fill the player hand to MAX_CARDS with low cards
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        serve(1, 0, 0, "full0");
        serve(5, 1, 0, "full1");
        serve(1, 2, 0, "full2");
        serve(6, 3, 0, "full3");
        wait_state(1, "full_turn");
        push(2, 2, 12, 11, 1, 0, 1);
        check("full_deal");
        for (int i = 0; i < 7; i++) begin
            pulse(1'b0, 1'b1, 1'b0, 1'b0);
            serve(hit_vals[i], 0, hit_dly[i], "full_hit");
            if (i < 6) wait_state(1, "full_back");
            if (i == 2) begin
                cmp("delayed_once_pcount", 32'(player_count), 32'd5);
                cmp("delayed_once_pscore", 32'(player_score), 32'd18);
            end
        end
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        serve(10, 1, 0, "full_dealer");
        wait_state(3, "full_res_state");
        push(9, 3, 14, 21, 3, 2, 0);
        check("full_result");
        cmp("full_p_slot8", 32'(player_values[35:32]), 32'd1);
        cmp("full_d_slot2", 32'(dealer_values[11:8]), 32'd10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
